// File: rtl/seg_scan_pkg.sv
// Shared types and limits for the seven-segment scan driver.
// Digit width is fixed by the downstream decoder's num input.
package seg_scan_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int DATA_W     = 4;

    typedef logic [DATA_W-1:0] digit_t;
    typedef logic [2:0]        sel_t;

endpackage

// File: rtl/seg_tick_gen.sv
// Refresh prescaler: counts enabled cycles and pulses step on the last one
// of every REFRESH_DIV-cycle period.
module seg_tick_gen #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic step
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (en) begin
            if (cnt_q == TERM) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Digit register file plus scan sequencer feeding the combinational 7-segment
// decoder; num and sel are registered together so they never disagree.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [3:0] num,
    output logic [2:0] sel,
    output logic       frame_tick
);

    localparam sel_t       LAST  = sel_t'(N_DIGITS - 1);
    localparam logic [3:0] N_LIM = 4'(N_DIGITS);

    logic   step;
    logic   wr_ok;
    digit_t digits_q [MAX_DIGITS];
    digit_t digits_d [MAX_DIGITS];
    sel_t   sel_q, sel_d;
    digit_t num_q, num_d;
    logic   frame_tick_q, frame_tick_d;

    seg_tick_gen #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .step(step)
    );

    always_comb begin
        digits_d = digits_q;
        wr_ok    = wr_en && ({1'b0, wr_addr} < N_LIM);
        if (clr) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                digits_d[i] = '0;
            end
        end else if (wr_ok) begin
            digits_d[wr_addr] = wr_data;
        end

        sel_d = sel_q;
        if (step) begin
            sel_d = (sel_q == LAST) ? '0 : sel_q + 1'b1;
        end
        frame_tick_d = step && (sel_q == LAST);

        // Reading the post-write file at the next position gives write forwarding for free.
        num_d = digits_d[sel_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the digit file is reset because the display must read 0 straight after reset.
            for (int i = 0; i < MAX_DIGITS; i++) begin
                digits_q[i] <= '0;
            end
            sel_q        <= '0;
            num_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            sel_q        <= sel_d;
            num_q        <= num_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign num        = num_q;
    assign sel        = sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: main instance (8 digits, div 4) plus
// 6-digit and div-1 variants sharing the same stimulus.
module tb_seg_scan_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;

    logic [3:0] num,  num6,  num1;
    logic [2:0] sel,  sel6,  sel1;
    logic       ft,   ft6,   ft1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.N_DIGITS(8), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .num(num), .sel(sel), .frame_tick(ft)
    );

    seg_scan_mux #(.N_DIGITS(6), .REFRESH_DIV(4)) dut6 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .num(num6), .sel(sel6), .frame_tick(ft6)
    );

    seg_scan_mux #(.N_DIGITS(8), .REFRESH_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .num(num1), .sel(sel1), .frame_tick(ft1)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; clr = 1'b0; wr_en = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic write_digit(input logic [2:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 8; i++) write_digit(3'(i), 4'(i + 1));
    endtask

    task automatic test_reset();
        en = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(9);
        #3 rst = 1'b1;
        #1;
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_async_sel: got %0d want 0", sel); end
        checks++; if (num !== 4'd0) begin errors++; $display("FAIL reset_async_num: got %0d want 0", num); end
        checks++; if (ft !== 1'b0) begin errors++; $display("FAIL reset_async_ft: got %0b want 0", ft); end
        tick(1);
        rst = 1'b0;
        tick(3);
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_3cyc_sel: got %0d want 0", sel); end
        tick(1);
        checks++; if (sel !== 3'd1) begin errors++; $display("FAIL reset_4cyc_sel: got %0d want 1", sel); end
        tick(4);
        checks++; if (sel !== 3'd2) begin errors++; $display("FAIL reset_8cyc_sel: got %0d want 2", sel); end
    endtask

    task automatic test_full_scan();
        logic [2:0] exp_sel;
        logic [3:0] exp_num;
        logic       exp_ft;
        do_reset();
        load_ramp();
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            exp_sel = 3'((c / 4) % 8);
            exp_num = 4'(exp_sel) + 4'd1;
            exp_ft  = (c == 32);
            checks++; if (sel !== exp_sel) begin errors++; $display("FAIL scan_sel c=%0d: got %0d want %0d", c, sel, exp_sel); end
            checks++; if (num !== exp_num) begin errors++; $display("FAIL scan_num c=%0d: got %0d want %0d", c, num, exp_num); end
            checks++; if (ft !== exp_ft) begin errors++; $display("FAIL scan_ft c=%0d: got %0b want %0b", c, ft, exp_ft); end
            tick(1);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        load_ramp();
        en = 1'b1;
        tick(12);
        en = 1'b0;
        checks++; if (sel !== 3'd3) begin errors++; $display("FAIL fwd_hold_sel: got %0d want 3", sel); end
        write_digit(3'd3, 4'hA);
        checks++; if (num !== 4'hA) begin errors++; $display("FAIL fwd_same_addr: got %0h want a", num); end
        write_digit(3'd5, 4'hB);
        checks++; if (num !== 4'hA) begin errors++; $display("FAIL fwd_other_addr: got %0h want a", num); end
        en = 1'b1;
        tick(4);
        checks++; if (sel !== 3'd4 || num !== 4'h5) begin errors++; $display("FAIL fwd_sel4: got sel=%0d num=%0h want sel=4 num=5", sel, num); end
        tick(4);
        checks++; if (sel !== 3'd5 || num !== 4'hB) begin errors++; $display("FAIL fwd_sel5: got sel=%0d num=%0h want sel=5 num=b", sel, num); end
    endtask

    task automatic test_priority();
        do_reset();
        load_ramp();
        clr = 1'b1;
        write_digit(3'd2, 4'h7);
        clr = 1'b0;
        checks++; if (num !== 4'd0) begin errors++; $display("FAIL clr_num: got %0d want 0", num); end
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (sel !== 3'(k) || num !== 4'd0) begin errors++; $display("FAIL clr_scan k=%0d: got sel=%0d num=%0d want sel=%0d num=0", k, sel, num, k); end
            tick(4);
        end
    endtask

    task automatic test_six_digits();
        logic [2:0] exp_sel;
        do_reset();
        for (int i = 0; i < 6; i++) write_digit(3'(i), 4'(i + 1));
        write_digit(3'd6, 4'hF);
        en = 1'b1;
        for (int c = 0; c < 28; c++) begin
            exp_sel = 3'((c / 4) % 6);
            checks++; if (sel6 !== exp_sel) begin errors++; $display("FAIL n6_sel c=%0d: got %0d want %0d", c, sel6, exp_sel); end
            checks++; if (num6 !== 4'(exp_sel) + 4'd1) begin errors++; $display("FAIL n6_num c=%0d: got %0d want %0d", c, num6, 4'(exp_sel) + 4'd1); end
            checks++; if (ft6 !== (c == 24)) begin errors++; $display("FAIL n6_ft c=%0d: got %0b want %0b", c, ft6, (c == 24)); end
            tick(1);
        end
    endtask

    task automatic test_enable_freeze();
        do_reset();
        en = 1'b1;
        tick(18);
        checks++; if (sel !== 3'd4) begin errors++; $display("FAIL frz_pre_sel: got %0d want 4", sel); end
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            checks++; if (sel !== 3'd4 || ft !== 1'b0) begin errors++; $display("FAIL frz_hold c=%0d: got sel=%0d ft=%0b want sel=4 ft=0", c, sel, ft); end
        end
        en = 1'b1;
        tick(1);
        checks++; if (sel !== 3'd4) begin errors++; $display("FAIL frz_resume1: got %0d want 4", sel); end
        tick(1);
        checks++; if (sel !== 3'd5) begin errors++; $display("FAIL frz_resume2: got %0d want 5", sel); end
    endtask

    task automatic test_div1();
        logic exp_ft;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 18; c++) begin
            exp_ft = (c > 0) && (c % 8 == 0);
            checks++; if (sel1 !== 3'(c % 8)) begin errors++; $display("FAIL div1_sel c=%0d: got %0d want %0d", c, sel1, c % 8); end
            checks++; if (ft1 !== exp_ft) begin errors++; $display("FAIL div1_ft c=%0d: got %0b want %0b", c, ft1, exp_ft); end
            tick(1);
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_forwarding();
        test_priority();
        test_six_digits();
        test_enable_freeze();
        test_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
